// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline register layouts, funct3 encodings and lane helpers.
package rv32i_types;
  localparam logic [2:0] load_f3_lb = 3'b000, load_f3_lh = 3'b001, load_f3_lw = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100, load_f3_lhu = 3'b101;
  localparam logic [2:0] store_f3_sb = 3'b000, store_f3_sh = 3'b001, store_f3_sw = 3'b010;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] mem_addr;
    logic [31:0] rs2_v;
  } ex_mem_reg_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_reg_t;
  // Size lives in funct3[1:0] for both loads and stores; the sign bit is irrelevant here.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    return sz == store_f3_sb[1:0] ? 4'b0001 << a : sz == store_f3_sh[1:0] ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == store_f3_sh[1:0] && a[0]) || (sz == store_f3_sw[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed lane of load data and sign/zero-extends it.
module load_extend
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] rd_v
);
  logic [15:0] lo;
  assign lo = 16'(rdata >> {addr, 3'b000});
  always_comb
    rd_v = funct3 == load_f3_lb  ? {{24{lo[7]}}, lo[7:0]} :
           funct3 == load_f3_lbu ? {24'b0, lo[7:0]} :
           funct3 == load_f3_lh  ? {{16{lo[15]}}, lo} :
           funct3 == load_f3_lhu ? {16'b0, lo} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: issues data-memory accesses, waits for the response and builds the MEM/WB register.
module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_reg,
  input  logic        ex_mem_valid,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output mem_wb_reg_t mem_wb_reg,
  output logic        mem_wb_valid
);
  mem_state_t state;
  logic [31:0] held_addr, held_wdata, shifted, ext;
  logic [3:0] mask;
  logic mem_op, mis, issue;
  mem_wb_reg_t pass, done;
  load_extend u_ext (
    .funct3(ex_mem_reg.funct3),
    .addr(ex_mem_reg.mem_addr[1:0]),
    .rdata(dmem_rdata),
    .rd_v(ext)
  );
  assign mem_op = ex_mem_reg.is_load | ex_mem_reg.is_store;
  assign mask = lane_mask(ex_mem_reg.funct3[1:0], ex_mem_reg.mem_addr[1:0]);
  assign mis = ex_mem_valid & mem_op & is_misaligned(ex_mem_reg.funct3[1:0], ex_mem_reg.mem_addr[1:0]);
  assign issue = ~rst & state == IDLE & ex_mem_valid & mem_op & ~mis;
  assign shifted = ex_mem_reg.rs2_v << {ex_mem_reg.mem_addr[1:0], 3'b000};
  assign dmem_rmask = issue & ex_mem_reg.is_load ? mask : 4'b0;
  assign dmem_wmask = issue & ex_mem_reg.is_store ? mask : 4'b0;
  assign dmem_addr = issue ? {ex_mem_reg.mem_addr[31:2], 2'b00} : held_addr;
  assign dmem_wdata = issue ? shifted : held_wdata;
  assign stall = ~rst & (issue | (state == WAIT & ~dmem_resp));
  // Upstream holds ex_mem_reg stable during WAIT, so the response record is built from it directly.
  always_comb begin
    pass = '0;
    pass.pc = ex_mem_reg.pc;
    pass.inst = ex_mem_reg.inst;
    pass.order = ex_mem_reg.order;
    pass.rd_s = ex_mem_reg.rd_s;
    pass.rd_v = ex_mem_reg.rd_v;
    pass.regf_we = ex_mem_reg.regf_we & ~mis;
    pass.commit = ex_mem_reg.commit;
    pass.misaligned = mis;
    pass.mem_addr = mem_op ? ex_mem_reg.mem_addr : 32'b0;
    done = pass;
    done.misaligned = 1'b0;
    done.rd_v = ex_mem_reg.is_load ? ext : ex_mem_reg.rd_v;
    done.regf_we = ex_mem_reg.is_load;
    done.mem_rmask = ex_mem_reg.is_load ? mask : 4'b0;
    done.mem_wmask = ex_mem_reg.is_store ? mask : 4'b0;
    done.mem_rdata = ex_mem_reg.is_load ? dmem_rdata : 32'b0;
    done.mem_wdata = ex_mem_reg.is_store ? held_wdata : 32'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_wb_valid <= 1'b0;
      mem_wb_reg <= '0;
      held_addr <= '0;
      held_wdata <= '0;
    end else if (state == IDLE) begin
      mem_wb_valid <= ex_mem_valid & ~issue;
      if (issue) begin
        state <= WAIT;
        held_addr <= {ex_mem_reg.mem_addr[31:2], 2'b00};
        held_wdata <= shifted;
      end else if (ex_mem_valid) mem_wb_reg <= pass;
    end else if (dmem_resp) begin
      state <= IDLE;
      mem_wb_valid <= 1'b1;
      mem_wb_reg <= done;
    end else mem_wb_valid <= 1'b0;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  import rv32i_types::*;
  logic clk = 0, rst = 1, ex_mem_valid = 0, dmem_resp = 0, stall, mem_wb_valid;
  ex_mem_reg_t ex_mem_reg = '0;
  mem_wb_reg_t mem_wb_reg;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0] dmem_rmask, dmem_wmask;
  int tests = 0, fails = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_mem_reg(ex_mem_reg), .ex_mem_valid(ex_mem_valid),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall), .mem_wb_reg(mem_wb_reg), .mem_wb_valid(mem_wb_valid)
  );

  always #5 clk = ~clk;

  function automatic ex_mem_reg_t mk(input logic [63:0] order, input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] rs2, input logic [31:0] rdv);
    ex_mem_reg_t e = '0;
    e.pc = 32'h100 + 32'(order) * 4;
    e.inst = 32'h13 + 32'(order);
    e.order = order;
    e.rd_s = 5'd3;
    e.rd_v = rdv;
    e.regf_we = ~st;
    e.commit = 1'b1;
    e.is_load = ld;
    e.is_store = st;
    e.funct3 = f3;
    e.mem_addr = addr;
    e.rs2_v = rs2;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", mem_wb_valid); end
    tests++; if (mem_wb_reg !== '0) begin fails++; $display("FAIL rst_reg got %h exp 0", mem_wb_reg); end
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL rst_stall_masks got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    tests++; if ({dmem_addr, dmem_wdata} !== 64'b0) begin fails++; $display("FAIL rst_held got %h exp 0", {dmem_addr, dmem_wdata}); end
    step();
    rst = 0;
  endtask

  task automatic test_alu();
    step();
    ex_mem_reg = mk(1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h5);
    ex_mem_valid = 1;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL alu_stall_masks got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    step();
    ex_mem_valid = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.rd_v !== 32'h5 || mem_wb_reg.order !== 64'd1) begin fails++; $display("FAIL alu_wb got v=%b rd_v=%h ord=%0d exp v=1 rd_v=5 ord=1", mem_wb_valid, mem_wb_reg.rd_v, mem_wb_reg.order); end
    tests++; if ({mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask, mem_wb_reg.regf_we} !== 9'b000000001) begin fails++; $display("FAIL alu_wb_masks got %b exp 000000001", {mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask, mem_wb_reg.regf_we}); end
    step();
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL bubble_valid got %b exp 0", mem_wb_valid); end
    dmem_resp = 1;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL idle_resp_outs got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    step();
    dmem_resp = 0;
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL idle_resp_valid got %b exp 0", mem_wb_valid); end
  endtask

  task automatic test_lb();
    step();
    ex_mem_reg = mk(2, 1, 0, load_f3_lb, 32'h1003, 32'h0, 32'h0);
    ex_mem_valid = 1;
    #1;
    tests++; if (dmem_rmask !== 4'b1000 || dmem_wmask !== 4'b0) begin fails++; $display("FAIL lb_masks got r=%b w=%b exp r=1000 w=0000", dmem_rmask, dmem_wmask); end
    tests++; if (dmem_addr !== 32'h1000 || stall !== 1'b1) begin fails++; $display("FAIL lb_issue got addr=%h stall=%b exp 1000 1", dmem_addr, stall); end
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      tests++; if (stall !== 1'b1 || dmem_rmask !== 4'b0 || dmem_addr !== 32'h1000 || mem_wb_valid !== 1'b0) begin fails++; $display("FAIL lb_wait%0d got stall=%b rmask=%b addr=%h v=%b exp 1 0000 1000 0", i, stall, dmem_rmask, dmem_addr, mem_wb_valid); end
    end
    step();
    dmem_resp = 1;
    dmem_rdata = 32'h80FFFFFF;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lb_resp_stall got %b exp 0", stall); end
    step();
    dmem_resp = 0;
    ex_mem_valid = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.rd_v !== 32'hFFFFFF80 || mem_wb_reg.regf_we !== 1'b1) begin fails++; $display("FAIL lb_wb got v=%b rd_v=%h we=%b exp 1 ffffff80 1", mem_wb_valid, mem_wb_reg.rd_v, mem_wb_reg.regf_we); end
    tests++; if (mem_wb_reg.mem_addr !== 32'h1003 || mem_wb_reg.mem_rmask !== 4'b1000 || mem_wb_reg.mem_rdata !== 32'h80FFFFFF) begin fails++; $display("FAIL lb_rvfi got addr=%h rmask=%b rdata=%h exp 1003 1000 80ffffff", mem_wb_reg.mem_addr, mem_wb_reg.mem_rmask, mem_wb_reg.mem_rdata); end
  endtask

  task automatic test_sh();
    step();
    ex_mem_reg = mk(3, 0, 1, store_f3_sh, 32'h2002, 32'h1234ABCD, 32'h0);
    ex_mem_valid = 1;
    #1;
    tests++; if (dmem_wmask !== 4'b1100 || dmem_rmask !== 4'b0 || dmem_wdata !== 32'hABCD0000 || dmem_addr !== 32'h2000) begin fails++; $display("FAIL sh_issue got w=%b r=%b wdata=%h addr=%h exp 1100 0000 abcd0000 2000", dmem_wmask, dmem_rmask, dmem_wdata, dmem_addr); end
    step();
    dmem_resp = 1;
    #1;
    tests++; if (dmem_wmask !== 4'b0 || dmem_wdata !== 32'hABCD0000 || dmem_addr !== 32'h2000 || stall !== 1'b0) begin fails++; $display("FAIL sh_wait got w=%b wdata=%h addr=%h stall=%b exp 0000 abcd0000 2000 0", dmem_wmask, dmem_wdata, dmem_addr, stall); end
    step();
    dmem_resp = 0;
    ex_mem_valid = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.regf_we !== 1'b0 || mem_wb_reg.mem_wmask !== 4'b1100 || mem_wb_reg.mem_wdata !== 32'hABCD0000) begin fails++; $display("FAIL sh_wb got v=%b we=%b wmask=%b wdata=%h exp 1 0 1100 abcd0000", mem_wb_valid, mem_wb_reg.regf_we, mem_wb_reg.mem_wmask, mem_wb_reg.mem_wdata); end
  endtask

  task automatic test_misaligned();
    step();
    ex_mem_reg = mk(4, 1, 0, load_f3_lw, 32'h3001, 32'h0, 32'h0);
    ex_mem_valid = 1;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL mis_outs got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    step();
    ex_mem_reg = mk(5, 0, 1, store_f3_sh, 32'h3003, 32'h0, 32'h0);
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.misaligned !== 1'b1 || mem_wb_reg.regf_we !== 1'b0 || mem_wb_reg.mem_rmask !== 4'b0) begin fails++; $display("FAIL mis_lw_wb got v=%b mis=%b we=%b rmask=%b exp 1 1 0 0000", mem_wb_valid, mem_wb_reg.misaligned, mem_wb_reg.regf_we, mem_wb_reg.mem_rmask); end
    tests++; if ({stall, dmem_wmask} !== 5'b0) begin fails++; $display("FAIL mis_sh_outs got %b exp 0", {stall, dmem_wmask}); end
    step();
    ex_mem_valid = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.misaligned !== 1'b1 || mem_wb_reg.order !== 64'd5) begin fails++; $display("FAIL mis_sh_wb got v=%b mis=%b ord=%0d exp 1 1 5", mem_wb_valid, mem_wb_reg.misaligned, mem_wb_reg.order); end
  endtask

  task automatic test_reset_wait();
    step();
    ex_mem_reg = mk(6, 1, 0, load_f3_lw, 32'h4000, 32'h0, 32'h0);
    ex_mem_valid = 1;
    step();
    #1;
    tests++; if (stall !== 1'b1 || dmem_addr !== 32'h4000) begin fails++; $display("FAIL rw_wait got stall=%b addr=%h exp 1 4000", stall, dmem_addr); end
    rst = 1;
    ex_mem_valid = 0;
    #1;
    tests++; if (stall !== 1'b0 || dmem_addr !== 32'h0 || mem_wb_valid !== 1'b0 || dmem_rmask !== 4'b0) begin fails++; $display("FAIL rw_async got stall=%b addr=%h v=%b rmask=%b exp 0 0 0 0000", stall, dmem_addr, mem_wb_valid, dmem_rmask); end
    step();
    rst = 0;
    step();
    step();
    dmem_resp = 1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL rw_resp_outs got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    step();
    dmem_resp = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b0 || mem_wb_reg.order !== 64'd0) begin fails++; $display("FAIL rw_ignored got v=%b ord=%0d exp 0 0", mem_wb_valid, mem_wb_reg.order); end
  endtask

  task automatic test_back_to_back();
    step();
    ex_mem_reg = mk(10, 1, 0, load_f3_lhu, 32'h5002, 32'h0, 32'h0);
    ex_mem_valid = 1;
    #1;
    tests++; if (dmem_rmask !== 4'b1100 || stall !== 1'b1) begin fails++; $display("FAIL b2b_lhu_issue got rmask=%b stall=%b exp 1100 1", dmem_rmask, stall); end
    step();
    dmem_resp = 1;
    dmem_rdata = 32'hBEEF1234;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask} !== 9'b0) begin fails++; $display("FAIL b2b_lhu_resp got %b exp 0", {stall, dmem_rmask, dmem_wmask}); end
    step();
    dmem_resp = 0;
    ex_mem_reg = mk(11, 0, 1, store_f3_sw, 32'h6000, 32'hCAFEF00D, 32'h0);
    #1;
    tests++; if (dmem_wmask !== 4'b1111 || dmem_rmask !== 4'b0 || dmem_wdata !== 32'hCAFEF00D || stall !== 1'b1) begin fails++; $display("FAIL b2b_sw_issue got w=%b r=%b wdata=%h stall=%b exp 1111 0000 cafef00d 1", dmem_wmask, dmem_rmask, dmem_wdata, stall); end
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.order !== 64'd10 || mem_wb_reg.rd_v !== 32'h0000BEEF || mem_wb_reg.mem_rmask !== 4'b1100) begin fails++; $display("FAIL b2b_lhu_wb got v=%b ord=%0d rd_v=%h rmask=%b exp 1 10 0000beef 1100", mem_wb_valid, mem_wb_reg.order, mem_wb_reg.rd_v, mem_wb_reg.mem_rmask); end
    step();
    dmem_resp = 1;
    #1;
    tests++; if ({stall, dmem_rmask, dmem_wmask, mem_wb_valid} !== 10'b0) begin fails++; $display("FAIL b2b_sw_resp got %b exp 0", {stall, dmem_rmask, dmem_wmask, mem_wb_valid}); end
    step();
    dmem_resp = 0;
    ex_mem_valid = 0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_wb_reg.order !== 64'd11 || mem_wb_reg.mem_wmask !== 4'b1111 || mem_wb_reg.mem_wdata !== 32'hCAFEF00D || mem_wb_reg.regf_we !== 1'b0) begin fails++; $display("FAIL b2b_sw_wb got v=%b ord=%0d wmask=%b wdata=%h we=%b exp 1 11 1111 cafef00d 0", mem_wb_valid, mem_wb_reg.order, mem_wb_reg.mem_wmask, mem_wb_reg.mem_wdata, mem_wb_reg.regf_we); end
    step();
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", mem_wb_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misaligned();
    test_reset_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
